mem_arbiter: RTL and testbench

- Shares one main-memory port between the instruction-cache and data-cache refill/writeback engines of the Riscv151 memory system.
- Grants one requester per transaction and issues its request to memory.
- Sequences write-data or read-response bursts of BEATS beats and routes each beat to the granted requester.
- Dcache has priority; a starvation counter guarantees icache forward progress.

---
 rtl/mem_arbiter_pkg.sv | 28 ++
 rtl/mem_arbiter_beat_counter.sv | 41 ++++
 rtl/mem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the main-memory arbiter of the Riscv151 memory system:
// FSM state encoding, memory request direction constants, default geometry and
// a helper that sizes the burst beat counter.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WDATA = 2'd2,
      ST_RDATA = 2'd3
   } arb_state_t;

   localparam logic MEM_RD = 1'b0;
   localparam logic MEM_WR = 1'b1;

   localparam int DEF_BEATS        = 4;
   localparam int DEF_DATA_W       = 128;
   localparam int DEF_STARVE_LIMIT = 8;

   // One extra bit so the counter can never wrap inside a burst.
   function automatic int beat_cnt_width(input int beats);
      return $clog2(beats) + 1;
   endfunction

endpackage

// File: rtl/mem_arbiter_beat_counter.sv
// -----------------------------------------------------------------------------
// arb_beat_counter
// Counts accepted beats of one burst and flags the final beat (count BEATS-1).
// Shared by the write-data and read-response phases of the arbiter.
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-high reset
//   i_clear  in   synchronous clear (held while a request is outstanding)
//   i_inc    in   one beat accepted this cycle
//   o_last   out  current beat is the final beat of the burst
// -----------------------------------------------------------------------------
module arb_beat_counter
   import mem_arbiter_pkg::*;
#(
   parameter int BEATS = DEF_BEATS
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_inc,
   output logic o_last
);

   localparam int CW = beat_cnt_width(BEATS);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // With BEATS=1 this is true from the first beat.
   assign o_last = (r_cnt == CW'(BEATS - 1));

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one main-memory port between the icache refill engine (reads only)
// and the dcache refill/writeback engine (reads and writes). One requester is
// granted per transaction; its request is issued to memory, then a burst of
// BEATS write beats (dcache -> memory) or read beats (memory -> requester) is
// sequenced. Dcache has priority, but an icache that has waited STARVE_LIMIT
// cycles wins the next arbitration.
// Ports:
//   clk, reset                 clock / asynchronous active-high reset
//   ic_req_*                   icache request handshake (address only)
//   ic_resp_*                  icache read beats (valid/last steered, data shared)
//   dc_req_*                   dcache request handshake (rw, address)
//   dc_wdata_*                 dcache write beats
//   dc_resp_*                  dcache read beats (valid/last steered, data shared)
//   mem_req_*                  request to main memory
//   mem_wdata_*                write beats to main memory
//   mem_resp_*                 read beats from main memory (no backpressure)
//   busy                       arbiter is not idle
//   grant_dc                   current/last grant went to the dcache
// -----------------------------------------------------------------------------
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int BEATS        = DEF_BEATS,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic              clk,
   input  logic              reset,
   // icache
   input  logic              ic_req_valid,
   input  logic [ADDR_W-1:0] ic_req_addr,
   output logic              ic_req_ready,
   output logic              ic_resp_valid,
   output logic              ic_resp_last,
   output logic [DATA_W-1:0] ic_resp_data,
   // dcache
   input  logic              dc_req_valid,
   input  logic              dc_req_rw,
   input  logic [ADDR_W-1:0] dc_req_addr,
   output logic              dc_req_ready,
   input  logic              dc_wdata_valid,
   input  logic [DATA_W-1:0] dc_wdata,
   output logic              dc_wdata_ready,
   output logic              dc_resp_valid,
   output logic              dc_resp_last,
   output logic [DATA_W-1:0] dc_resp_data,
   // memory
   output logic              mem_req_valid,
   output logic              mem_req_rw,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_req_ready,
   output logic              mem_wdata_valid,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_wdata_ready,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_resp_data,
   // status
   output logic              busy,
   output logic              grant_dc
);

   localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   arb_state_t        r_state;
   logic [ADDR_W-1:0] r_addr;
   logic              r_rw;
   logic              r_grant_dc;
   logic              r_mem_req_valid;
   logic [SW-1:0]     r_starve_cnt;

   logic w_any_req;
   logic w_pick_dc;
   logic w_req_fire;
   logic w_in_wdata;
   logic w_wbeat;
   logic w_rbeat;
   logic w_last;
   logic w_ic_served;

   // Arbitration: dcache wins a tie unless the icache has starved long enough.
   assign w_any_req = ic_req_valid || dc_req_valid;
   assign w_pick_dc = dc_req_valid && !(ic_req_valid && (r_starve_cnt >= STARVE_MAX));

   assign w_req_fire = r_mem_req_valid && mem_req_ready;
   assign w_in_wdata = (r_state == ST_WDATA);
   assign w_wbeat    = w_in_wdata && dc_wdata_valid && mem_wdata_ready;
   // Beats outside RDATA are strays and are dropped here.
   assign w_rbeat    = (r_state == ST_RDATA) && mem_resp_valid;

   // The icache is the current grant only while a transaction is in flight.
   assign w_ic_served = (r_state != ST_IDLE) && !r_grant_dc;

   arb_beat_counter #(
      .BEATS (BEATS)
   ) u_beat_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_clear (r_state == ST_REQ),
      .i_inc   (w_wbeat || w_rbeat),
      .o_last  (w_last)
   );

   // -------------------------------------------------------------------------
   // Transaction FSM
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state         <= ST_IDLE;
         r_addr          <= '0;
         r_rw            <= MEM_RD;
         r_grant_dc      <= 1'b0;
         r_mem_req_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  r_addr          <= w_pick_dc ? dc_req_addr : ic_req_addr;
                  r_rw            <= w_pick_dc ? dc_req_rw : MEM_RD;
                  r_grant_dc      <= w_pick_dc;
                  r_mem_req_valid <= 1'b1;
                  r_state         <= ST_REQ;
               end
            end
            ST_REQ: begin
               // The latched request is issued even if the requester drops it.
               if (w_req_fire) begin
                  r_mem_req_valid <= 1'b0;
                  r_state         <= (r_rw == MEM_WR) ? ST_WDATA : ST_RDATA;
               end
            end
            ST_WDATA: begin
               if (w_wbeat && w_last) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_RDATA: begin
               if (w_rbeat && w_last) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Starvation counter: counts every cycle the icache wants memory but is not
   // being served, including while the dcache holds the port.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_starve_cnt <= '0;
      end else if ((r_state == ST_IDLE) && ic_req_valid && !w_pick_dc) begin
         r_starve_cnt <= '0;
      end else if (ic_req_valid && !w_ic_served && (r_starve_cnt < STARVE_MAX)) begin
         r_starve_cnt <= r_starve_cnt + SW'(1);
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign busy          = (r_state != ST_IDLE);
   assign grant_dc      = r_grant_dc;

   assign mem_req_valid = r_mem_req_valid;
   assign mem_req_rw    = r_rw;
   assign mem_req_addr  = r_addr;

   assign ic_req_ready  = w_req_fire && !r_grant_dc;
   assign dc_req_ready  = w_req_fire && r_grant_dc;

   assign mem_wdata_valid = w_in_wdata && dc_wdata_valid;
   assign mem_wdata       = dc_wdata;
   assign dc_wdata_ready  = w_in_wdata && mem_wdata_ready;

   assign ic_resp_valid = w_rbeat && !r_grant_dc;
   assign ic_resp_last  = w_rbeat && !r_grant_dc && w_last;
   assign dc_resp_valid = w_rbeat && r_grant_dc;
   assign dc_resp_last  = w_rbeat && r_grant_dc && w_last;

   // Read data is broadcast; only the valids are steered.
   assign ic_resp_data  = mem_resp_data;
   assign dc_resp_data  = mem_resp_data;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 128;
   localparam int BEATS  = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              ic_req_valid;
   logic [ADDR_W-1:0] ic_req_addr;
   logic              ic_req_ready;
   logic              ic_resp_valid;
   logic              ic_resp_last;
   logic [DATA_W-1:0] ic_resp_data;
   logic              dc_req_valid;
   logic              dc_req_rw;
   logic [ADDR_W-1:0] dc_req_addr;
   logic              dc_req_ready;
   logic              dc_wdata_valid;
   logic [DATA_W-1:0] dc_wdata;
   logic              dc_wdata_ready;
   logic              dc_resp_valid;
   logic              dc_resp_last;
   logic [DATA_W-1:0] dc_resp_data;
   logic              mem_req_valid;
   logic              mem_req_rw;
   logic [ADDR_W-1:0] mem_req_addr;
   logic              mem_req_ready;
   logic              mem_wdata_valid;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_wdata_ready;
   logic              mem_resp_valid;
   logic [DATA_W-1:0] mem_resp_data;
   logic              busy;
   logic              grant_dc;

   int n_tests = 0;
   int n_fail  = 0;

   // Control outputs packed for compact per-cycle comparison:
   // busy grant_dc mem_req_valid mem_req_rw | ic_req_ready dc_req_ready ic_resp_valid ic_resp_last |
   // dc_resp_valid dc_resp_last mem_wdata_valid dc_wdata_ready
   logic [11:0] ctl;
   assign ctl = {busy, grant_dc, mem_req_valid, mem_req_rw,
                 ic_req_ready, dc_req_ready, ic_resp_valid, ic_resp_last,
                 dc_resp_valid, dc_resp_last, mem_wdata_valid, dc_wdata_ready};

   mem_arbiter #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .BEATS        (BEATS),
      .STARVE_LIMIT (8)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .ic_req_valid    (ic_req_valid),
      .ic_req_addr     (ic_req_addr),
      .ic_req_ready    (ic_req_ready),
      .ic_resp_valid   (ic_resp_valid),
      .ic_resp_last    (ic_resp_last),
      .ic_resp_data    (ic_resp_data),
      .dc_req_valid    (dc_req_valid),
      .dc_req_rw       (dc_req_rw),
      .dc_req_addr     (dc_req_addr),
      .dc_req_ready    (dc_req_ready),
      .dc_wdata_valid  (dc_wdata_valid),
      .dc_wdata        (dc_wdata),
      .dc_wdata_ready  (dc_wdata_ready),
      .dc_resp_valid   (dc_resp_valid),
      .dc_resp_last    (dc_resp_last),
      .dc_resp_data    (dc_resp_data),
      .mem_req_valid   (mem_req_valid),
      .mem_req_rw      (mem_req_rw),
      .mem_req_addr    (mem_req_addr),
      .mem_req_ready   (mem_req_ready),
      .mem_wdata_valid (mem_wdata_valid),
      .mem_wdata       (mem_wdata),
      .mem_wdata_ready (mem_wdata_ready),
      .mem_resp_valid  (mem_resp_valid),
      .mem_resp_data   (mem_resp_data),
      .busy            (busy),
      .grant_dc        (grant_dc)
   );

   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ic_req_valid    = 1'b0;
      ic_req_addr     = '0;
      dc_req_valid    = 1'b0;
      dc_req_rw       = 1'b0;
      dc_req_addr     = '0;
      dc_wdata_valid  = 1'b0;
      dc_wdata        = '0;
      mem_req_ready   = 1'b0;
      mem_wdata_ready = 1'b0;
      mem_resp_valid  = 1'b0;
      mem_resp_data   = '0;
   endtask

   function automatic logic [DATA_W-1:0] beat_data(input int tag, input int k);
      return {32'hC0DE_0000 + 32'(tag), 32'h5A5A_0000 + 32'(k),
              32'h0BAD_F00D ^ 32'(tag * 16 + k), 32'(k)};
   endfunction

   // ---------------------------------------------------------------------
   task automatic test_reset();
      idle_inputs();
      ic_req_valid   = 1'b1;
      ic_req_addr    = 32'h0000_9000;
      mem_req_ready  = 1'b1;
      mem_resp_valid = 1'b1;
      dc_wdata_valid = 1'b1;
      reset          = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if (ctl !== 12'b0) begin
         n_fail++;
         $display("FAIL reset_ctl got=%b exp=%b", ctl, 12'b0);
      end
      n_tests++;
      if (mem_req_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_addr got=%h exp=%h", mem_req_addr, 32'h0);
      end
      idle_inputs();
      reset = 1'b0;
      next_cycle();
      $display("[TB] reset checked");
   endtask

   // ---------------------------------------------------------------------
   task automatic test_ic_read();
      logic [11:0] exp_ctl [7] = '{12'b0000_0000_0000, 12'b1010_1000_0000,
                                   12'b1000_0010_0000, 12'b1000_0010_0000,
                                   12'b1000_0010_0000, 12'b1000_0011_0000,
                                   12'b0000_0000_0000};
      ic_req_addr    = 32'h0000_1000;
      mem_req_ready  = 1'b1;
      mem_resp_valid = 1'b1;
      for (int c = 0; c < 7; c++) begin
         ic_req_valid  = (c <= 1);
         mem_resp_data = beat_data(1, c - 2);
         #1;
         n_tests++;
         if (ctl !== exp_ctl[c]) begin
            n_fail++;
            $display("FAIL ic_read_ctl c=%0d got=%b exp=%b", c, ctl, exp_ctl[c]);
         end
         if (c == 1) begin
            n_tests++;
            if (mem_req_addr !== 32'h0000_1000) begin
               n_fail++;
               $display("FAIL ic_read_addr got=%h exp=%h", mem_req_addr, 32'h0000_1000);
            end
         end
         if (c >= 2 && c <= 5) begin
            n_tests++;
            if (ic_resp_data !== beat_data(1, c - 2)) begin
               n_fail++;
               $display("FAIL ic_read_data c=%0d got=%h exp=%h", c, ic_resp_data, beat_data(1, c - 2));
            end
         end
         next_cycle();
      end
      idle_inputs();
      $display("[TB] icache read 0x1000 checked");
   endtask

   // ---------------------------------------------------------------------
   task automatic test_priority();
      logic [11:0] exp_ctl [13] = '{12'b0000_0000_0000, 12'b1110_0100_0000,
                                    12'b1100_0000_1000, 12'b1100_0000_1000,
                                    12'b1100_0000_1000, 12'b1100_0000_1100,
                                    12'b0100_0000_0000, 12'b1010_1000_0000,
                                    12'b1000_0010_0000, 12'b1000_0010_0000,
                                    12'b1000_0010_0000, 12'b1000_0011_0000,
                                    12'b0000_0000_0000};
      ic_req_addr    = 32'h0000_1000;
      dc_req_addr    = 32'h0000_2000;
      dc_req_rw      = 1'b0;
      mem_req_ready  = 1'b1;
      mem_resp_valid = 1'b1;
      for (int c = 0; c < 13; c++) begin
         dc_req_valid  = (c <= 1);
         ic_req_valid  = (c <= 7);
         mem_resp_data = beat_data(2, c);
         #1;
         n_tests++;
         if (ctl !== exp_ctl[c]) begin
            n_fail++;
            $display("FAIL prio_ctl c=%0d got=%b exp=%b", c, ctl, exp_ctl[c]);
         end
         if (c == 1 || c == 7) begin
            n_tests++;
            if (mem_req_addr !== ((c == 1) ? 32'h0000_2000 : 32'h0000_1000)) begin
               n_fail++;
               $display("FAIL prio_addr c=%0d got=%h exp=%h", c, mem_req_addr,
                        (c == 1) ? 32'h0000_2000 : 32'h0000_1000);
            end
         end
         if (c == 3) begin
            n_tests++;
            if (dc_resp_data !== beat_data(2, 3)) begin
               n_fail++;
               $display("FAIL prio_dc_data got=%h exp=%h", dc_resp_data, beat_data(2, 3));
            end
         end
         next_cycle();
      end
      idle_inputs();
      $display("[TB] dcache-over-icache priority checked");
   endtask

   // ---------------------------------------------------------------------
   task automatic test_starvation();
      logic [31:0] exp_addr [4] = '{32'h2000, 32'h2000, 32'h1000, 32'h2000};
      logic        exp_gdc  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      logic [31:0] got_addr [4];
      logic        got_gdc  [4];
      int          n = 0;
      dc_req_valid   = 1'b1;
      dc_req_rw      = 1'b0;
      dc_req_addr    = 32'h0000_2000;
      ic_req_valid   = 1'b1;
      ic_req_addr    = 32'h0000_1000;
      mem_req_ready  = 1'b1;
      mem_resp_valid = 1'b1;
      for (int c = 0; c < 80 && n < 4; c++) begin
         mem_resp_data = beat_data(3, c);
         #1;
         if (mem_req_valid && mem_req_ready) begin
            got_addr[n] = mem_req_addr;
            got_gdc[n]  = grant_dc;
            n++;
         end
         next_cycle();
      end
      dc_req_valid = 1'b0;
      ic_req_valid = 1'b0;
      for (int c = 0; c < 20 && busy; c++) next_cycle();
      n_tests++;
      if (n != 4 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL starve_count got_grants=%0d busy=%b exp_grants=4 busy=0", n, busy);
      end
      for (int i = 0; i < n; i++) begin
         n_tests++;
         if (got_addr[i] !== exp_addr[i] || got_gdc[i] !== exp_gdc[i]) begin
            n_fail++;
            $display("FAIL starve_grant i=%0d got=%h/%b exp=%h/%b", i, got_addr[i], got_gdc[i],
                     exp_addr[i], exp_gdc[i]);
         end
      end
      idle_inputs();
      next_cycle();
      $display("[TB] starvation override checked");
   endtask

   // ---------------------------------------------------------------------
   task automatic test_write();
      logic [11:0] exp_ctl [10] = '{12'b0100_0000_0000, 12'b1111_0100_0000,
                                    12'b1101_0000_0011, 12'b1101_0000_0010,
                                    12'b1101_0000_0011, 12'b1101_0000_0010,
                                    12'b1101_0000_0011, 12'b1101_0000_0010,
                                    12'b1101_0000_0011, 12'b0101_0000_0000};
      int k = 0;
      dc_req_addr    = 32'h0000_3000;
      dc_req_rw      = 1'b1;
      mem_req_ready  = 1'b1;
      mem_resp_valid = 1'b1;   // strays: must never surface as a response
      dc_wdata_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         dc_req_valid    = (c <= 1);
         mem_wdata_ready = (c % 2 == 0);
         dc_wdata        = beat_data(4, k);
         mem_resp_data   = beat_data(9, c);
         #1;
         n_tests++;
         if (ctl !== exp_ctl[c]) begin
            n_fail++;
            $display("FAIL write_ctl c=%0d got=%b exp=%b", c, ctl, exp_ctl[c]);
         end
         if (c >= 2 && c <= 8) begin
            n_tests++;
            if (mem_wdata !== beat_data(4, k)) begin
               n_fail++;
               $display("FAIL write_data c=%0d got=%h exp=%h", c, mem_wdata, beat_data(4, k));
            end
            if (mem_wdata_ready) k++;
         end
         next_cycle();
      end
      idle_inputs();
      $display("[TB] dcache write with stalled wdata_ready checked");
   endtask

   // ---------------------------------------------------------------------
   task automatic test_req_stall();
      logic [11:0] exp_ctl [12] = '{12'b0101_0000_0000, 12'b1010_0000_0000,
                                    12'b1010_0000_0000, 12'b1010_0000_0000,
                                    12'b1010_0000_0000, 12'b1010_0000_0000,
                                    12'b1010_1000_0000, 12'b1000_0010_0000,
                                    12'b1000_0010_0000, 12'b1000_0010_0000,
                                    12'b1000_0011_0000, 12'b0000_0000_0000};
      dc_req_rw      = 1'b1;
      dc_req_addr    = 32'h0000_7000;
      mem_resp_valid = 1'b1;
      for (int c = 0; c < 12; c++) begin
         // Icache changes address and drops valid before ready: must be ignored.
         ic_req_valid  = (c <= 2);
         ic_req_addr   = (c < 2) ? 32'h0000_4000 : 32'hDEAD_0000;
         dc_req_valid  = (c >= 1 && c <= 5);
         mem_req_ready = (c >= 6);
         mem_resp_data = beat_data(5, c);
         #1;
         n_tests++;
         if (ctl !== exp_ctl[c]) begin
            n_fail++;
            $display("FAIL stall_ctl c=%0d got=%b exp=%b", c, ctl, exp_ctl[c]);
         end
         if (c >= 1 && c <= 6) begin
            n_tests++;
            if (mem_req_addr !== 32'h0000_4000) begin
               n_fail++;
               $display("FAIL stall_addr c=%0d got=%h exp=%h", c, mem_req_addr, 32'h0000_4000);
            end
         end
         next_cycle();
      end
      idle_inputs();
      $display("[TB] request stall with protocol violation checked");
   endtask

   // ---------------------------------------------------------------------
   task automatic test_reset_midburst();
      logic [11:0] exp_pre [5] = '{12'b0000_0000_0000, 12'b1010_1000_0000,
                                   12'b1000_0010_0000, 12'b1000_0010_0000,
                                   12'b1000_0010_0000};
      logic [11:0] exp_new [7] = '{12'b0000_0000_0000, 12'b1010_1000_0000,
                                   12'b1000_0010_0000, 12'b1000_0010_0000,
                                   12'b1000_0010_0000, 12'b1000_0011_0000,
                                   12'b0000_0000_0000};
      ic_req_addr    = 32'h0000_5000;
      mem_req_ready  = 1'b1;
      mem_resp_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         ic_req_valid  = (c <= 1);
         mem_resp_data = beat_data(6, c);
         #1;
         n_tests++;
         if (ctl !== exp_pre[c]) begin
            n_fail++;
            $display("FAIL rst_pre_ctl c=%0d got=%b exp=%b", c, ctl, exp_pre[c]);
         end
         if (c < 4) next_cycle();
      end
      // Beat 2 is on the bus; reset between clock edges.
      reset = 1'b1;
      #1;
      n_tests++;
      if (ctl !== 12'b0 || mem_req_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_async got=%b/%h exp=%b/%h", ctl, mem_req_addr, 12'b0, 32'h0);
      end
      next_cycle();
      reset = 1'b0;
      // Leftover beats from the aborted burst must be ignored.
      for (int c = 0; c < 2; c++) begin
         mem_resp_data = beat_data(7, c);
         #1;
         n_tests++;
         if (ctl !== 12'b0) begin
            n_fail++;
            $display("FAIL rst_stray c=%0d got=%b exp=%b", c, ctl, 12'b0);
         end
         next_cycle();
      end
      ic_req_addr = 32'h0000_6000;
      for (int c = 0; c < 7; c++) begin
         ic_req_valid  = (c <= 1);
         mem_resp_data = beat_data(8, c - 2);
         #1;
         n_tests++;
         if (ctl !== exp_new[c]) begin
            n_fail++;
            $display("FAIL rst_new_ctl c=%0d got=%b exp=%b", c, ctl, exp_new[c]);
         end
         if (c == 1) begin
            n_tests++;
            if (mem_req_addr !== 32'h0000_6000) begin
               n_fail++;
               $display("FAIL rst_new_addr got=%h exp=%h", mem_req_addr, 32'h0000_6000);
            end
         end
         if (c == 5) begin
            n_tests++;
            if (ic_resp_data !== beat_data(8, 3)) begin
               n_fail++;
               $display("FAIL rst_new_data got=%h exp=%h", ic_resp_data, beat_data(8, 3));
            end
         end
         next_cycle();
      end
      idle_inputs();
      $display("[TB] reset during read burst checked");
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_ic_read();
      test_priority();
      test_starvation();
      test_write();
      test_req_stall();
      test_reset_midburst();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
